// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - host-side configuration-chain loader with pad isolation control
// Optional readback verify of the chain is built when CCFF_LOADER_READBACK_EN is defined.
module ccff_loader #(
    parameter int CHAIN_LEN = 9,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              config_enable,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WCNT_W  = $clog2(N_WORDS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] WORDS_TOTAL = WCNT_W'(N_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   buf_q;
    logic                buf_vld_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WCNT_W-1:0]   words_q;
    logic                head_q;
    logic                en_q;
    logic                iso_q;
    logic                busy_q;
    logic                done_q;

    logic                last_bit;
    logic                hs;
    logic [CNT_W-1:0]    cnt_d;

    // The buffer can take the next word while its final bit is being shifted,
    // which is what keeps back-to-back words gapless.
    assign last_bit = buf_vld_q && (idx_q == LAST_IDX);
    assign wr_ready = (state_q == S_LOAD) && (words_q != WORDS_TOTAL) && (!buf_vld_q || last_bit);
    assign hs       = wr_valid && wr_ready;
    assign cnt_d    = (cnt_q == LAST_CNT) ? cnt_q : cnt_q + 1'b1;

`ifdef CCFF_LOADER_READBACK_EN
    logic [15:0]      crc_ld_q;
    logic [15:0]      crc_vf_q;
    logic [CNT_W-1:0] vcnt_q;
    logic             err_q;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    assign err = err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign err         = 1'b0;
`endif

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            words_q   <= '0;
            head_q    <= 1'b0;
            en_q      <= 1'b0;
            iso_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef CCFF_LOADER_READBACK_EN
            crc_ld_q  <= 16'hFFFF;
            crc_vf_q  <= 16'hFFFF;
            vcnt_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    en_q <= 1'b0;
                    if (start) begin
                        state_q   <= S_LOAD;
                        busy_q    <= 1'b1;
                        iso_q     <= 1'b0;
                        cnt_q     <= '0;
                        words_q   <= '0;
                        buf_vld_q <= 1'b0;
                        idx_q     <= '0;
`ifdef CCFF_LOADER_READBACK_EN
                        err_q     <= 1'b0;
                        crc_ld_q  <= 16'hFFFF;
                        crc_vf_q  <= 16'hFFFF;
                        vcnt_q    <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        words_q <= words_q + 1'b1;
                        buf_q   <= wr_data;
                    end
                    if (buf_vld_q) begin
                        head_q <= buf_q[idx_q];
                        en_q   <= 1'b1;
                        cnt_q  <= cnt_d;
                        idx_q  <= last_bit ? '0 : idx_q + 1'b1;
`ifdef CCFF_LOADER_READBACK_EN
                        crc_ld_q <= crc_step(crc_ld_q, buf_q[idx_q]);
`endif
                        if (cnt_d == LAST_CNT) begin
                            buf_vld_q <= 1'b0;
`ifdef CCFF_LOADER_READBACK_EN
                            state_q   <= S_VERIFY;
`else
                            state_q   <= S_FIN;
`endif
                        end else if (last_bit) begin
                            buf_vld_q <= hs;
                        end
                    end else begin
                        en_q <= 1'b0;
                        if (hs) begin
                            buf_vld_q <= 1'b1;
                            idx_q     <= '0;
                        end
                    end
                end
`ifdef CCFF_LOADER_READBACK_EN
                // The registered head is an extra stage in the recirculation loop, so
                // sample the tail only on idle cycles to keep the ring CHAIN_LEN long.
                S_VERIFY: begin
                    if (en_q) begin
                        en_q <= 1'b0;
                        if (vcnt_q == LAST_CNT) begin
                            err_q   <= (crc_vf_q != crc_ld_q);
                            state_q <= S_FIN;
                        end
                    end else begin
                        head_q   <= ccff_tail;
                        en_q     <= 1'b1;
                        crc_vf_q <= crc_step(crc_vf_q, ccff_tail);
                        vcnt_q   <= vcnt_q + 1'b1;
                    end
                end
`endif
                S_FIN: begin
                    en_q    <= 1'b0;
                    done_q  <= 1'b1;
                    iso_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    en_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ccff_head     = head_q;
    assign config_enable = en_q;
    assign IO_ISOL_N     = iso_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - self-checking bench for ccff_loader with a behavioural chain model
`timescale 1ns/1ps
module tb_ccff_loader;
    localparam int CHAIN_LEN = 9;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = 16;
    localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WB        = N_WORDS * WORD_W;
`ifdef CCFF_LOADER_READBACK_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic              prog_clk;
    logic              pReset_n;
    logic              start;
    logic              wr_valid;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              config_enable;
    logic              IO_ISOL_N;
    logic              busy;
    logic              done;
    logic              err;

    ccff_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .config_enable(config_enable),
        .IO_ISOL_N(IO_ISOL_N), .busy(busy), .done(done), .err(err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Downstream tile chain: one flop per config bit, shifting on config_enable.
    logic [CHAIN_LEN-1:0] chain = '0;
    logic [CHAIN_LEN-1:0] flip_mask;
    always @(posedge prog_clk) begin
        if (|flip_mask) chain <= chain ^ flip_mask;
        else if (config_enable) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end
    assign ccff_tail = chain[CHAIN_LEN-1];

    bit caps[$];
    int en_cyc[$];
    int cyc = 0, done_cnt = 0, hs_cnt = 0;
    always @(negedge prog_clk) begin
        #2;
        cyc++;
        if (config_enable) begin
            caps.push_back(ccff_head);
            en_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (wr_valid && wr_ready) hs_cnt++;
    end

    int checks = 0, errors = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [CHAIN_LEN-1:0] model_bits(input logic [WB-1:0] words);
        bit q[$];
        logic [CHAIN_LEN-1:0] r;
        for (int k = 0; k < N_WORDS; k++)
            for (int b = 0; b < WORD_W; b++) q.push_back(words[k*WORD_W+b]);
        r = '0;
        for (int i = 0; i < CHAIN_LEN; i++) r[i] = q[i];
        return r;
    endfunction

    task automatic run_load(input logic [WB-1:0] words, input int gap,
                            input logic [CHAIN_LEN-1:0] exp_bits, input bit exp_err,
                            input bit check_chain);
        int base, hs0, d0, n, span;
        bit seen;
        logic prev_iso;
        logic [CHAIN_LEN-1:0] got, got_rb, exp_chain;
        base = caps.size(); hs0 = hs_cnt; d0 = done_cnt;
        @(negedge prog_clk); start = 1'b1; wr_valid = 1'b0;
        @(negedge prog_clk); start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_iso", IO_ISOL_N, 0);
        check("accept_err", err, 0);
        for (int k = 0; k < N_WORDS; k++) begin
            if (k > 0) begin
                @(negedge prog_clk);
                if (gap > 0) begin
                    wr_valid = 1'b0;
                    n = 0;
                    while (!wr_ready && n < 50) begin @(negedge prog_clk); n++; end
                    repeat (gap) @(negedge prog_clk);
                end
            end
            wr_data  = words[k*WORD_W +: WORD_W];
            wr_valid = 1'b1;
            n = 0;
            while (!wr_ready && n < 50) begin @(negedge prog_clk); n++; end
            check("word_ready", wr_ready, 1);
        end
        seen = 0; prev_iso = IO_ISOL_N;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge prog_clk);
            if (done) seen = 1; else prev_iso = IO_ISOL_N;
        end
        check("done_seen", seen, 1);
        check("done_iso", IO_ISOL_N, 1);
        check("iso_before_done", prev_iso, 0);
        check("done_busy", busy, 0);
        check("done_en", config_enable, 0);
        check("done_err", err, exp_err);
        check("done_ready", wr_ready, 0);
        wr_valid = 1'b0;
        check("shift_count", caps.size() - base, PASSES * CHAIN_LEN);
        got = '0; got_rb = '0; span = -1;
        if (caps.size() >= base + PASSES * CHAIN_LEN) begin
            for (int i = 0; i < CHAIN_LEN; i++) got[i] = caps[base+i];
            for (int i = 0; i < CHAIN_LEN; i++) got_rb[i] = caps[base+(PASSES-1)*CHAIN_LEN+i];
            span = en_cyc[base+CHAIN_LEN-1] - en_cyc[base] + 1 - CHAIN_LEN;
        end
        check("head_bits", got, exp_bits);
        check("stall_cycles", span, gap);
        check("handshakes", hs_cnt - hs0, N_WORDS);
        if (check_chain) begin
            for (int i = 0; i < CHAIN_LEN; i++) exp_chain[CHAIN_LEN-1-i] = exp_bits[i];
            check("chain_contents", chain, exp_chain);
            check("readback_bits", got_rb, exp_bits);
        end
        @(negedge prog_clk);
        check("done_pulse_width", done, 0);
        check("done_count", done_cnt - d0, 1);
        check("idle_iso_held", IO_ISOL_N, 1);
    endtask

    typedef struct {
        logic [WB-1:0]        words;
        int                   gap;
        logic [CHAIN_LEN-1:0] exp_bits;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int base, n;
        logic [WB-1:0] w;
        int g;
        start = 0; wr_valid = 0; wr_data = '0; pReset_n = 0; flip_mask = '0;
        vecs[0] = '{16'h01A5, 0, 9'h1A5};
        vecs[1] = '{16'h01A5, 3, 9'h1A5};
        vecs[2] = '{16'hFE00, 1, 9'h000};
        vecs[3] = '{16'h00FF, 0, 9'h0FF};
        vecs[4] = '{16'hFF3C, 2, 9'h13C};
        vecs[5] = '{16'h025A, 4, 9'h05A};

        #3;
        check("rst_head", ccff_head, 0);
        check("rst_en", config_enable, 0);
        check("rst_iso", IO_ISOL_N, 0);
        check("rst_ready", wr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        repeat (2) @(negedge prog_clk);
        pReset_n = 1;
        wr_valid = 1; wr_data = 8'hFF;
        @(negedge prog_clk);
        check("idle_ready", wr_ready, 0);
        wr_valid = 0;

        for (int v = 0; v < 6; v++)
            run_load(vecs[v].words, vecs[v].gap, vecs[v].exp_bits, 1'b0, 1'b1);

        // start while busy is ignored
        base = caps.size();
        fork
            run_load(16'h01A5, 0, 9'h1A5, 1'b0, 1'b1);
            begin
                n = 0;
                while (caps.size() - base < 4 && n < 100) begin @(posedge prog_clk); #2; n++; end
                @(negedge prog_clk); start = 1'b1;
                @(negedge prog_clk); start = 1'b0;
                check("ignored_start_busy", busy, 1);
                check("ignored_start_iso", IO_ISOL_N, 0);
            end
        join

        // reset in the middle of a load
        base = caps.size();
        @(negedge prog_clk); start = 1'b1;
        @(negedge prog_clk); start = 1'b0; wr_data = 8'hA5; wr_valid = 1'b1;
        n = 0;
        while (caps.size() - base < 5 && n < 100) begin @(negedge prog_clk); n++; end
        pReset_n = 0;
        #1;
        check("midrst_en", config_enable, 0);
        check("midrst_iso", IO_ISOL_N, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", wr_ready, 0);
        wr_valid = 0;
        @(negedge prog_clk); pReset_n = 1;
        run_load(16'h01A5, 0, 9'h1A5, 1'b0, 1'b1);

`ifdef CCFF_LOADER_READBACK_EN
        // corrupt one chain flop between load and verify
        base = caps.size();
        fork
            run_load(16'h01A5, 0, 9'h1A5, 1'b1, 1'b0);
            begin
                n = 0;
                while (caps.size() - base < CHAIN_LEN && n < 100) begin @(posedge prog_clk); #2; n++; end
                flip_mask = 9'b000010000;
                @(posedge prog_clk); #1;
                flip_mask = '0;
            end
        join
        run_load(16'h01A5, 2, 9'h1A5, 1'b0, 1'b1);
`endif

        for (int r = 0; r < 12; r++) begin
            w = WB'($urandom);
            g = int'($urandom_range(0, 4));
            run_load(w, g, model_bits(w), 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ccff_loader.md
Name: ccff_loader

Overview:
- Drives the configuration-chain protocol from the host side: converts a word stream into the serial bitstream on ccff_head and gates config_enable.
- Manages IO_ISOL_N so the pads stay isolated until the chain is fully loaded.
- Sits above the grid tiles. Its ccff_head feeds the first tile's ccff_head, and the last tile's ccff_tail returns to it.

Parameters:
- CHAIN_LEN, 9, total configuration bits in the downstream chain (>=1)
- WORD_W, 8, width of the input bitstream word (>=1)
- CNT_W, 16, bit-counter width (must satisfy 2**CNT_W > CHAIN_LEN)

Ports:
- prog_clk  in  1  programming clock; all state on rising edge
- pReset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load
- wr_valid  in  1  bitstream word valid
- wr_data  in  WORD_W  bitstream word; bit 0 is shifted first
- wr_ready  out  1  loader accepts wr_data this cycle
- ccff_head  out  1  serial data into the chain
- ccff_tail  in  1  serial data returned from the end of the chain
- config_enable  out  1  chain shift enable; each high cycle is exactly one shift
- IO_ISOL_N  out  1  0 = pads isolated, 1 = pads released
- busy  out  1  load (or verify) in progress
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky verify mismatch; cleared by start

Behaviour:
- Reset (asynchronous, pReset_n=0): state IDLE; counters cleared; word buffer empty. All outputs 0: ccff_head, config_enable, IO_ISOL_N, wr_ready, busy, done, err.
- All outputs are registered except wr_ready, which is combinational from state and buffer status.
- States: IDLE, LOAD, VERIFY (only when the macro is defined), FIN.
- IDLE:
  - start=1 -> LOAD.
  - Same edge: busy<=1, IO_ISOL_N<=0, err<=0, bit counter<=0.
- LOAD, word buffer:
  - One WORD_W buffer plus a bit index.
  - wr_ready=1 when the buffer is empty, or when its last valid bit is being presented this cycle, and words are still owed. Words owed = ceil(CHAIN_LEN/WORD_W) minus words accepted.
  - A handshake (wr_valid & wr_ready) loads the buffer. Back-to-back words give gapless shifting.
- LOAD, shifting:
  - In a cycle where the buffer holds a bit: ccff_head=bit, config_enable=1, bit counter +1.
  - Buffer empty (host stall): config_enable=0, ccff_head holds its last value, the chain does not move.
- LOAD, last bit:
  - When the counter reaches CHAIN_LEN, the remaining bits of the final word are discarded. The next cycle has config_enable=0.
  - State goes to VERIFY, or to FIN if the macro is not defined.
  - Exactly CHAIN_LEN config_enable-high cycles occur per load.
- FIN (lasts one cycle):
  - done=1, IO_ISOL_N<=1, busy<=0, then -> IDLE.
  - IO_ISOL_N stays 1 until the next accepted start.
- start while busy is ignored. wr_valid in IDLE or FIN is ignored (wr_ready=0).
- Reset mid-load: immediate return to reset values, IO_ISOL_N=0. The chain contents are undefined and the host must reload.
- Counter arithmetic is unsigned, with no wrap: the counter saturates at CHAIN_LEN.

Optional Feature:
- Macro: CCFF_LOADER_READBACK_EN.
- Defined, signature during LOAD:
  - A 16-bit CRC (poly 0x1021, init 0xFFFF) is computed over every shifted bit, in shift order.
- Defined, VERIFY state:
  - Runs CHAIN_LEN shift cycles with config_enable=1 and ccff_head=ccff_tail (recirculation preserves the chain contents).
  - A second CRC is computed over ccff_tail.
  - After the final shift: err<=1 if the two CRCs differ, then -> FIN.
  - IO_ISOL_N is still released in FIN regardless of err; software decides what to do.
- Not defined: no CRC logic, no VERIFY state, err is tied to 0, and LOAD goes directly to FIN.

Test Plan:
- CHAIN_LEN=9, WORD_W=8: start, then words 0xA5, 0x01 with wr_valid held -> ccff_head = 1,0,1,0,0,1,0,1,1 over 9 consecutive config_enable cycles. No third wr_ready. done pulses once. IO_ISOL_N rises in the done cycle.
- Same data with a 3-cycle wr_valid gap between words -> config_enable low for exactly those stall cycles. Still 9 shift cycles; identical bit sequence.
- start pulsed again after 4 shifts -> ignored: busy stays 1 and the total shift count is 9.
- pReset_n=0 after 5 shifts -> same cycle: config_enable=0, IO_ISOL_N=0, busy=0. A new start reloads from bit 0.
- READBACK_EN with a 9-flop behavioural chain model -> 18 shift cycles, err=0. Force one chain flop inverted before VERIFY -> err=1, done=1.
- Second start after completion -> IO_ISOL_N drops to 0 on accept, err clears, and a full reload repeats.
